// File: rtl/dht_sensor_ctrl.sv
// dht_sensor_ctrl: DHT11/DHT22 single-wire controller with start pulse, 40-bit decode, checksum and auto-trigger.
// Optional `define DHT_GLITCH_FILTER_EN adds a 4-sample debounce on the synchronised line.
module dht_sensor_ctrl #(
  parameter int CLK_HZ           = 50000000,
  parameter int SENSOR_TYPE      = 0,
  parameter int BIT_THRESH_US    = 48,
  parameter int TIMEOUT_US       = 200,
  parameter int SAMPLE_PERIOD_MS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        auto_en,
  inout  wire         dht11,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        valid_data,
  output logic        busy,
  output logic [1:0]  error,
  output logic        done
);
  localparam int DIV      = CLK_HZ / 1000000;
  localparam int START_US = SENSOR_TYPE != 0 ? 1100 : 18000;
  localparam int RESP_US  = 40;
  localparam int PH_SAT   = START_US > TIMEOUT_US + 1 ? START_US : TIMEOUT_US + 1;
  localparam int PER_US   = SAMPLE_PERIOD_MS * 1000;
  localparam int TW       = $clog2(DIV + 1);
  localparam int PW       = $clog2(PH_SAT + 1);
  localparam int AW       = $clog2(PER_US + 1);
  typedef enum logic [3:0] {
    IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, DONE, ERR
  } state_t;
  state_t        state, state_n;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase;
  logic [AW-1:0] per_cnt;
  logic [1:0]    sync;
  logic          line, line_q, fall, rise, tick, trig, ph_to;
  logic [39:0]   data;
  logic [5:0]    bit_idx;
  logic [7:0]    sum;
  assign dht11 = state == START_LOW ? 1'b0 : 1'bz;
  assign busy  = !(state inside {IDLE, DONE, ERR});
  assign done  = state inside {DONE, ERR};
  assign tick  = tick_cnt == TW'(DIV - 1);
  assign fall  = line_q & ~line;
  assign rise  = ~line_q & line;
  assign ph_to = phase > PW'(TIMEOUT_US);
  assign sum   = data[39:32] + data[31:24] + data[23:16] + data[15:8];
  assign trig  = state == IDLE && (start || (auto_en && per_cnt == AW'(PER_US - 1)));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tick_cnt <= '0;
      sync     <= 2'b11;
      line_q   <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      sync     <= {sync[0], dht11};
      line_q   <= line;
    end
`ifdef DHT_GLITCH_FILTER_EN
  logic [1:0] db_cnt;
  // line follows the synchroniser only after 4 consecutive differing samples
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      db_cnt <= '0;
      line   <= 1'b1;
    end else if (sync[1] == line) db_cnt <= '0;
    else if (db_cnt == 2'd3) begin
      db_cnt <= '0;
      line   <= sync[1];
    end else db_cnt <= db_cnt + 1'b1;
`else
  assign line = sync[1];
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (trig) state_n = START_LOW;
      START_LOW: if (phase >= PW'(START_US)) state_n = WAIT_RESP;
      WAIT_RESP: state_n = fall ? RESP_LOW : phase > PW'(RESP_US) ? ERR : state;
      RESP_LOW:  state_n = rise ? RESP_HIGH : ph_to ? ERR : state;
      RESP_HIGH: state_n = fall ? BIT_LOW : ph_to ? ERR : state;
      BIT_LOW:   state_n = rise ? BIT_HIGH : ph_to ? ERR : state;
      BIT_HIGH:  state_n = fall ? (bit_idx == 6'd39 ? CHECK : BIT_LOW) : ph_to ? ERR : state;
      CHECK:     state_n = sum == data[7:0] ? DONE : ERR;
      default:   state_n = IDLE;
    endcase
  end
  // phase restarts on every state change so each state times its own phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      phase       <= '0;
      per_cnt     <= '0;
      data        <= '0;
      bit_idx     <= '0;
      humidity    <= '0;
      temperature <= '0;
      valid_data  <= 1'b0;
      error       <= 2'd0;
    end else begin
      state   <= state_n;
      phase   <= state_n != state ? '0 : (tick && phase != PW'(PH_SAT)) ? phase + 1'b1 : phase;
      per_cnt <= (!auto_en || trig) ? '0 : (tick && per_cnt != AW'(PER_US - 1)) ? per_cnt + 1'b1 : per_cnt;
      if (trig) begin
        valid_data <= 1'b0;
        error      <= 2'd0;
      end
      if (state == RESP_HIGH && fall) bit_idx <= '0;
      if (state == BIT_HIGH && fall) begin
        data    <= {data[38:0], phase > PW'(BIT_THRESH_US)};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == CHECK && sum == data[7:0]) begin
        humidity    <= data[39:24];
        temperature <= data[23:8];
        valid_data  <= 1'b1;
      end
      if (state_n == ERR && state != ERR)
        error <= state == WAIT_RESP ? 2'd1 : state == CHECK ? 2'd3 : 2'd2;
    end
endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb_dht_sensor_ctrl: random and directed frames from a sensor model, checked against a checksum/retention model.
`timescale 1ns/1ps
module tb_dht_sensor_ctrl;
  logic        clk = 0, rst = 0, start = 0, auto_en = 0, start1 = 0, sens_low = 0;
  wire         dq, dq1;
  logic [15:0] humidity, temperature, humidity1, temperature1;
  logic        valid_data, busy, done, valid1, busy1, done1;
  logic [1:0]  error, error1;
  int          total = 0, bad = 0, cyc = 0, n_done = 0, done_cyc = 0;
  logic [15:0] s_hum, s_tmp, exp_hum = 0, exp_tmp = 0;
  logic        s_val, s_busy;
  logic [1:0]  s_err;

  pullup (dq);
  pullup (dq1);
  assign dq = sens_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dht_sensor_ctrl #(.CLK_HZ(1000000), .SENSOR_TYPE(1), .BIT_THRESH_US(48), .TIMEOUT_US(200),
                    .SAMPLE_PERIOD_MS(6)) u_dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .dht11(dq),
    .humidity(humidity), .temperature(temperature), .valid_data(valid_data),
    .busy(busy), .error(error), .done(done));

  dht_sensor_ctrl #(.CLK_HZ(1000000), .SENSOR_TYPE(0)) u_dht11 (
    .clk(clk), .rst(rst), .start(start1), .auto_en(1'b0), .dht11(dq1),
    .humidity(humidity1), .temperature(temperature1), .valid_data(valid1),
    .busy(busy1), .error(error1), .done(done1));

  always @(negedge clk)
    if (done) begin
      n_done++;
      done_cyc = cyc;
      s_hum = humidity;
      s_tmp = temperature;
      s_val = valid_data;
      s_err = error;
      s_busy = busy;
    end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    total++;
    assert (v >= lo && v <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic hold(input bit lo, input int us);
    sens_low = lo;
    repeat (us) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // Waits for the host start pulse, then answers with nbits bits (-1: no answer).
  // nbits < 40 leaves the last bit's high phase running forever.
  task automatic sensor(input logic [39:0] f, input int nbits, output int low_len,
                        output int fall_cyc, output int rel_cyc);
    int n = 0;
    low_len = -1;
    fall_cyc = 0;
    rel_cyc = 0;
    while (dq !== 1'b0 && n < 30000) begin @(negedge clk); n++; end
    if (dq !== 1'b0) return;
    fall_cyc = cyc;
    n = 0;
    while (dq === 1'b0 && n < 30000) begin @(negedge clk); n++; end
    low_len = n;
    rel_cyc = cyc;
    if (nbits < 0) return;
    hold(0, 20);
    hold(1, 80);
    hold(0, 80);
    for (int i = 0; i < nbits; i++) begin
      hold(1, 50);
      sens_low = 0;
      if (i < nbits - 1 || nbits == 40) repeat (f[39 - i] ? 70 : 27) @(negedge clk);
    end
    if (nbits == 40) hold(1, 50);
    sens_low = 0;
    rel_cyc = cyc;
  endtask

  task automatic settle(input int base, input string tag);
    int n = 0;
    while (n_done == base && n < 30000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, ".done_pulses"}, n_done - base, 1);
    chk({tag, ".busy_at_done"}, s_busy, 0);
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".line_released"}, dq, 1);
  endtask

  task automatic expect_frame(input logic [39:0] f, input string tag);
    logic [7:0] sum;
    bit ok;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    ok = sum == f[7:0];
    if (ok) begin
      exp_hum = f[39:24];
      exp_tmp = f[23:8];
    end
    chk({tag, ".hum"}, s_hum, exp_hum);
    chk({tag, ".tmp"}, s_tmp, exp_tmp);
    chk({tag, ".valid"}, s_val, ok);
    chk({tag, ".err"}, s_err, ok ? 0 : 3);
  endtask

  task automatic txn(input logic [39:0] f, input string tag);
    int base, lo, fc, rc;
    base = n_done;
    pulse_start();
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".valid_cleared"}, valid_data, 0);
    sensor(f, 40, lo, fc, rc);
    chk_rng({tag, ".start_low"}, lo, 1100, 1104);
    settle(base, tag);
    expect_frame(f, tag);
  endtask

  initial begin
    int lo, fc, fc2, rc, base, n;
    logic [31:0] d;
    logic [7:0] c;
    repeat (3) @(negedge clk);
    chk("rst.hum", humidity, 0);
    chk("rst.tmp", temperature, 0);
    chk("rst.valid", valid_data, 0);
    chk("rst.busy", busy, 0);
    chk("rst.err", error, 0);
    chk("rst.done", done, 0);
    chk("rst.line", dq, 1);
    rst = 1;
    repeat (3) @(negedge clk);
    txn(40'h37_00_18_00_4F, "good");
    txn(40'h37_00_18_00_50, "badsum");
    txn(40'h02_8C_80_65_73, "neg");
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      c = d[31:24] + d[23:16] + d[15:8] + d[7:0];
      if ($urandom_range(3) == 0) c = c + 8'd1 + 8'($urandom_range(200));
      txn({d, c}, "rand");
    end
    base = n_done;
    pulse_start();
    sensor(40'h0, -1, lo, fc, rc);
    chk_rng("noresp.start_low", lo, 1100, 1104);
    settle(base, "noresp");
    chk("noresp.err", s_err, 1);
    chk("noresp.valid", s_val, 0);
    chk("noresp.hum", s_hum, exp_hum);
    chk_rng("noresp.delay", done_cyc - rc, 40, 48);
    base = n_done;
    pulse_start();
    sensor(40'hA5_5A_C3_3C_00, 13, lo, fc, rc);
    settle(base, "tmo");
    chk("tmo.err", s_err, 2);
    chk("tmo.valid", s_val, 0);
    chk("tmo.tmp", s_tmp, exp_tmp);
    chk_rng("tmo.delay", done_cyc - rc, 200, 212);
    auto_en = 1;
    base = n_done;
    pulse_start();
    sensor(40'h11_22_33_44_AA, 40, lo, fc, rc);
    settle(base, "auto1");
    expect_frame(40'h11_22_33_44_AA, "auto1");
    base = n_done;
    sensor(40'h40_01_02_03_46, 40, lo, fc2, rc);
    auto_en = 0;
    chk_rng("auto.period", fc2 - fc, 5999, 6001);
    settle(base, "auto2");
    expect_frame(40'h40_01_02_03_46, "auto2");
    pulse_start();
    sensor(40'hFF_00_FF_00_FE, 5, lo, fc, rc);
    repeat (10) @(negedge clk);
    chk("mid.busy", busy, 1);
    rst = 0;
    #1;
    chk("mid.hum", humidity, 0);
    chk("mid.tmp", temperature, 0);
    chk("mid.valid", valid_data, 0);
    chk("mid.busy0", busy, 0);
    chk("mid.err", error, 0);
    chk("mid.done", done, 0);
    chk("mid.line", dq, 1);
    @(negedge clk);
    rst = 1;
    exp_hum = 0;
    exp_tmp = 0;
    repeat (3) @(negedge clk);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    n = 0;
    while (dq1 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (dq1 === 1'b0 && n < 30000) begin @(negedge clk); n++; end
    chk_rng("dht11.start_low", n, 18000, 18004);
    n = 0;
    while (done1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("dht11.done", done1, 1);
    chk("dht11.err", error1, 1);
    chk("dht11.valid", valid1, 0);
    chk("dht11.busy", busy1, 0);
    @(negedge clk);
    chk("dht11.line", dq1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
